// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
//   Round-robin burst arbiter that lets NUM_REQ requesters share the write
//   port of an asynchronous FIFO. Runs entirely in the write clock domain.
//
//   A requester wins in an IDLE cycle (the decision cycle, no beat moves),
//   owns the port for up to MAX_BURST beats, and loses it after the last
//   beat or as soon as its req_valid drops. The released owner then has the
//   lowest priority for the next round.
//
//   Optional feature: define FIFO_ARB_LAST_EN to add the req_last input and
//   switch to packet lock. In that mode a grant is released only by a beat
//   that carries req_last, and neither MAX_BURST nor a valid drop releases it.
//
// Ports
//   wclk         write-domain clock
//   wreset       asynchronous, active-low reset
//   req_valid    [NUM_REQ]             per-requester beat valid
//   req_data     [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     [NUM_REQ]             end-of-packet marker (FIFO_ARB_LAST_EN only)
//   req_ready    [NUM_REQ]             beat accepted this cycle (owner only)
//   fifo_full    FIFO write-side full flag
//   fifo_valid   FIFO write strobe
//   fifo_data    [DATA_WIDTH]          FIFO write data (owner's slice)
//   grant        [NUM_REQ]             one-hot owner, zero when idle
//   grant_id     [ID_W]                index of current / most recent owner
//   dbg_busy     FSM state (1 = BUSY)
//   dbg_beat_cnt [CNT_W]               beats moved in the current burst
//
// Handshake: a beat moves in exactly the cycle where the owner's req_valid
// and its req_ready are both high; req_ready is never high without
// fifo_valid, and fifo_valid is high only when the FIFO is not full.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wreset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LAST_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_valid,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          dbg_busy,
  output logic [CNT_W-1:0]              dbg_beat_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              owner_valid;
  logic              xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Round-robin search starts one past the most recent owner, so the owner
  // just released is examined last.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(grant_id_q) + i) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_valid = req_valid[grant_id_q];
  assign xfer        = (state_q == BUSY) && owner_valid && !fifo_full;

`ifndef FIFO_ARB_LAST_EN
  logic last_beat;
  assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
`endif

  // Next-state logic. fifo_full alone never changes state or count: it only
  // suppresses the transfer.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BUSY;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
`ifdef FIFO_ARB_LAST_EN
        // Packet lock: the counter is informational and simply wraps on
        // packets longer than its range.
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_id_q]) state_d = IDLE;
        end
`else
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wreset) begin
    if (!wreset) begin
      state_q    <= IDLE;
      grant_id_q <= ID_W'(NUM_REQ - 1);  // first round favours requester 0
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i]     = (state_q == BUSY) && (grant_id_q == ID_W'(i));
      req_ready[i] = xfer && (grant_id_q == ID_W'(i));
    end
  end

  assign fifo_valid   = xfer;
  assign fifo_data    = data_arr[grant_id_q];
  assign grant_id     = grant_id_q;
  assign dbg_busy     = (state_q == BUSY);
  assign dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wreset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
`ifdef FIFO_ARB_LAST_EN
  logic [3:0]  req_last;
`endif
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_valid;
  logic [7:0]  fifo_data;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        dbg_busy;
  logic [2:0]  dbg_beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 wclk = ~wclk;

  fifo_wr_arb #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .wclk        (wclk),
    .wreset      (wreset),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef FIFO_ARB_LAST_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_valid  (fifo_valid),
    .fifo_data   (fifo_data),
    .grant       (grant),
    .grant_id    (grant_id),
    .dbg_busy    (dbg_busy),
    .dbg_beat_cnt(dbg_beat_cnt)
  );

  // ---------------- driver / check tasks ----------------
  // Inputs change 2 time units after the active edge; checks follow.
  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [3:0] g, input int gid, input logic fv);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_gid"}, 32'(grant_id), gid);
    chk({tag, "_fv"}, 32'(fifo_valid), 32'(fv));
  endtask

  function automatic logic [7:0] dat(input int o);
    logic [31:0] d;
    d = 32'hD3C2B1A0;
    return d[o*8 +: 8];
  endfunction

  task automatic chk_reset(input string tag);
    chk_cyc(tag, 4'b0000, 3, 1'b0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_busy"}, 32'(dbg_busy), 0);
    chk({tag, "_cnt"}, 32'(dbg_beat_cnt), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wreset    = 1'b0;
    req_valid = 4'b0000;
    fifo_full = 1'b0;
    req_data  = 32'hD3C2B1A0;
`ifdef FIFO_ARB_LAST_EN
    req_last  = 4'b0000;
`endif
    repeat (2) tick();
    chk_reset("rst");

`ifndef FIFO_ARB_LAST_EN
    // Single requester 0: decision cycle, 4 beats, 1 idle, regrant.
    wreset = 1'b1; req_valid = 4'b0001; #1;
    chk_cyc("r0_decide", 4'b0000, 3, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk_cyc($sformatf("r0_beat%0d", b), 4'b0001, 0, 1'b1);
      chk($sformatf("r0_data%0d", b), 32'(fifo_data), 32'(dat(0)));
      chk($sformatf("r0_ready%0d", b), 32'(req_ready), 32'h1);
      chk($sformatf("r0_cnt%0d", b), 32'(dbg_beat_cnt), b);
    end
    tick();
    chk_cyc("r0_gap", 4'b0000, 0, 1'b0);
    chk("r0_gap_ready", 32'(req_ready), 0);
    tick();
    chk_cyc("r0_regrant", 4'b0001, 0, 1'b1);
    tick(); req_valid = 4'b0000; #1;
    chk_cyc("r0_drop", 4'b0001, 0, 1'b0);
    tick();
    chk_cyc("r0_drop_idle", 4'b0000, 0, 1'b0);

    // Asynchronous reset, then all four requesting: order 0,1,2,3,0.
    wreset = 1'b0; #1;
    chk_reset("rst2");
    tick(); wreset = 1'b1; req_valid = 4'b1111; #1;
    chk_cyc("rr_decide", 4'b0000, 3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        chk_cyc($sformatf("rr%0d_b%0d", k, b), 4'(1 << (k % 4)), k % 4, 1'b1);
        chk($sformatf("rr%0d_data%0d", k, b), 32'(fifo_data), 32'(dat(k % 4)));
        chk($sformatf("rr%0d_ready%0d", k, b), 32'(req_ready), 32'(1 << (k % 4)));
        chk($sformatf("rr%0d_cnt%0d", k, b), 32'(dbg_beat_cnt), b);
      end
      tick();
      if (k == 4) begin req_valid = 4'b0000; #1; end
      chk_cyc($sformatf("rr%0d_gap", k), 4'b0000, k % 4, 1'b0);
    end

    // Requester 2 with fifo_full stalling for 3 cycles.
    tick(); req_valid = 4'b0100; #1;
    chk_cyc("st_decide", 4'b0000, 0, 1'b0);
    tick();
    chk_cyc("st_b0", 4'b0100, 2, 1'b1);
    chk("st_data", 32'(fifo_data), 32'(dat(2)));
    tick(); fifo_full = 1'b1; #1;
    for (int s = 0; s < 3; s++) begin
      if (s != 0) tick();
      chk_cyc($sformatf("st_full%0d", s), 4'b0100, 2, 1'b0);
      chk($sformatf("st_full_ready%0d", s), 32'(req_ready), 0);
      chk($sformatf("st_full_cnt%0d", s), 32'(dbg_beat_cnt), 1);
    end
    tick(); fifo_full = 1'b0; #1;
    for (int b = 1; b < 4; b++) begin
      if (b != 1) tick();
      chk_cyc($sformatf("st_b%0d", b), 4'b0100, 2, 1'b1);
      chk($sformatf("st_cnt%0d", b), 32'(dbg_beat_cnt), b);
    end
    tick(); req_valid = 4'b0110; #1;
    chk_cyc("st_release", 4'b0000, 2, 1'b0);

    // Requester 1 drops valid after 2 beats; requester 2 wins next.
    tick();
    chk_cyc("dr_b0", 4'b0010, 1, 1'b1);
    chk("dr_data", 32'(fifo_data), 32'(dat(1)));
    tick();
    chk("dr_cnt1", 32'(dbg_beat_cnt), 1);
    chk("dr_fv1", 32'(fifo_valid), 1);
    tick(); req_valid = 4'b0100; #1;
    chk_cyc("dr_drop", 4'b0010, 1, 1'b0);
    chk("dr_drop_ready", 32'(req_ready), 0);
    tick();
    chk_cyc("dr_idle", 4'b0000, 1, 1'b0);
    tick();
    chk_cyc("dr_next", 4'b0100, 2, 1'b1);
    chk("dr_next_data", 32'(fifo_data), 32'(dat(2)));

    // Reset in the middle of requester 3's burst.
    tick(); req_valid = 4'b1000; #1;
    chk_cyc("mr_drop2", 4'b0100, 2, 1'b0);
    tick();
    chk_cyc("mr_idle", 4'b0000, 2, 1'b0);
    tick();
    chk_cyc("mr_b0", 4'b1000, 3, 1'b1);
    chk("mr_data", 32'(fifo_data), 32'(dat(3)));
    tick();
    chk("mr_cnt1", 32'(dbg_beat_cnt), 1);
    wreset = 1'b0; req_valid = 4'b1001; #1;
    chk_reset("mr_rst");
    tick(); wreset = 1'b1; #1;
    chk_cyc("mr_decide", 4'b0000, 3, 1'b0);
    tick();
    chk_cyc("mr_win0", 4'b0001, 0, 1'b1);
    chk("mr_win0_data", 32'(fifo_data), 32'(dat(0)));
`else
    // Packet lock: 6 beats, valid gap before beat 3, req_last on beat 6.
    wreset = 1'b1; req_valid = 4'b0001; #1;
    chk_cyc("pk_decide", 4'b0000, 3, 1'b0);
    for (int b = 1; b <= 6; b++) begin
      tick();
      if (b == 3) begin
        req_valid = 4'b0000; #1;
        chk_cyc("pk_gap", 4'b0001, 0, 1'b0);
        tick(); req_valid = 4'b0001; #1;
      end
      if (b == 6) begin req_last = 4'b0001; #1; end
      chk_cyc($sformatf("pk_b%0d", b), 4'b0001, 0, 1'b1);
    end
    tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk_cyc("pk_release", 4'b0000, 0, 1'b0);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
